// File: rtl/painterengine_gpu_sync_fifo_if.sv
// Request/status bundle of the single-clock GPU FIFO.
// The master side (producer/consumer logic) drives requests; the FIFO is the slave.
interface painterengine_gpu_sync_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 7
);
  logic                  i_wire_flush;
  logic                  i_wire_write;
  logic [DATA_WIDTH-1:0] i_wire_data_in;
  logic                  i_wire_read;
  logic [CW-1:0]         i_wire_almost_full_threshold;
  logic [CW-1:0]         i_wire_almost_empty_threshold;
  logic [DATA_WIDTH-1:0] o_wire_data_out;
  logic                  o_wire_data_valid;
  logic                  o_wire_full;
  logic                  o_wire_almost_full;
  logic                  o_wire_empty;
  logic                  o_wire_almost_empty;
  logic [CW-1:0]         o_wire_data_count;
  logic [CW-1:0]         o_wire_empty_count;
  logic                  o_wire_overflow;
  logic                  o_wire_underflow;

  modport master (
    output i_wire_flush, i_wire_write, i_wire_data_in, i_wire_read,
           i_wire_almost_full_threshold, i_wire_almost_empty_threshold,
    input  o_wire_data_out, o_wire_data_valid, o_wire_full, o_wire_almost_full,
           o_wire_empty, o_wire_almost_empty, o_wire_data_count, o_wire_empty_count,
           o_wire_overflow, o_wire_underflow
  );

  modport slave (
    input  i_wire_flush, i_wire_write, i_wire_data_in, i_wire_read,
           i_wire_almost_full_threshold, i_wire_almost_empty_threshold,
    output o_wire_data_out, o_wire_data_valid, o_wire_full, o_wire_almost_full,
           o_wire_empty, o_wire_almost_empty, o_wire_data_count, o_wire_empty_count,
           o_wire_overflow, o_wire_underflow
  );
endinterface

// File: rtl/painterengine_gpu_sync_fifo.sv
// Single-clock FIFO with FWFT or registered read, live thresholds, flush and sticky errors.
// Latency: FWFT head visible the cycle after the write; registered data the cycle after the read.
module painterengine_gpu_sync_fifo #(
  parameter int PARAM_DATA_WIDTH = 32,
  parameter int PARAM_FIFO_DEPTH = 64,
  parameter bit PARAM_FWFT       = 1'b1
) (
  input logic                          i_wire_write_clock,
  input logic                          i_wire_resetn,
  painterengine_gpu_sync_fifo_if.slave fifo_if
);
  localparam int            CW      = $clog2(PARAM_FIFO_DEPTH) + 1;
  localparam int            AW      = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(PARAM_FIFO_DEPTH);

  logic [PARAM_DATA_WIDTH-1:0] mem_q [PARAM_FIFO_DEPTH];

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [CW-1:0]               count;
  logic                        not_empty;
  logic                        rd_ok, wr_ok;
  logic                        rd_acc, wr_acc;
  logic [PARAM_DATA_WIDTH-1:0] head_dat;

  // Pointers carry one extra wrap bit, so the difference covers 0..DEPTH exactly.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign not_empty = (count != '0);
  assign head_dat  = mem_q[rd_ptr_q[AW-1:0]];

  assign rd_ok  = fifo_if.i_wire_read && not_empty;
  assign wr_ok  = fifo_if.i_wire_write && ((count < DEPTH_C) || rd_ok);
  assign rd_acc = rd_ok && !fifo_if.i_wire_flush;
  assign wr_acc = wr_ok && !fifo_if.i_wire_flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (fifo_if.i_wire_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + CW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end
      if (fifo_if.i_wire_write && !wr_ok) begin
        overflow_d = 1'b1;
      end
      if (fifo_if.i_wire_read && !rd_ok) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_wire_write_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is left unreset so it can map onto RAM macros.
  always_ff @(posedge i_wire_write_clock) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= fifo_if.i_wire_data_in;
    end
  end

  generate
    if (PARAM_FWFT) begin : g_fwft
      assign fifo_if.o_wire_data_out   = not_empty ? head_dat : '0;
      assign fifo_if.o_wire_data_valid = not_empty;
    end else begin : g_reg
      logic [PARAM_DATA_WIDTH-1:0] data_out_q, data_out_d;
      logic                        data_valid_q, data_valid_d;

      always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        if (rd_acc) begin
          data_out_d   = head_dat;
          data_valid_d = 1'b1;
        end
      end

      always_ff @(posedge i_wire_write_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
          data_out_q   <= '0;
          data_valid_q <= 1'b0;
        end else begin
          data_out_q   <= data_out_d;
          data_valid_q <= data_valid_d;
        end
      end

      assign fifo_if.o_wire_data_out   = data_out_q;
      assign fifo_if.o_wire_data_valid = data_valid_q;
    end
  endgenerate

  assign fifo_if.o_wire_full         = (count == DEPTH_C);
  assign fifo_if.o_wire_empty        = !not_empty;
  assign fifo_if.o_wire_almost_full  = (count >= fifo_if.i_wire_almost_full_threshold);
  assign fifo_if.o_wire_almost_empty = (count <= fifo_if.i_wire_almost_empty_threshold);
  assign fifo_if.o_wire_data_count   = count;
  assign fifo_if.o_wire_empty_count  = DEPTH_C - count;
  assign fifo_if.o_wire_overflow     = overflow_q;
  assign fifo_if.o_wire_underflow    = underflow_q;

endmodule

// File: tb/tb_painterengine_gpu_sync_fifo.sv
// Bench for the GPU sync FIFO: an FWFT and a registered-read instance share one stimulus
// stream; a queue model is compared every cycle, plus literal directed expectations.
module tb_painterengine_gpu_sync_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          fl, wr, rd;
  logic [DW-1:0] din;
  logic [CW-1:0] af_thr, ae_thr;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  painterengine_gpu_sync_fifo_if #(.DATA_WIDTH(DW), .CW(CW)) if_f ();
  painterengine_gpu_sync_fifo_if #(.DATA_WIDTH(DW), .CW(CW)) if_r ();

  assign if_f.i_wire_flush = fl;
  assign if_f.i_wire_write = wr;
  assign if_f.i_wire_data_in = din;
  assign if_f.i_wire_read = rd;
  assign if_f.i_wire_almost_full_threshold = af_thr;
  assign if_f.i_wire_almost_empty_threshold = ae_thr;
  assign if_r.i_wire_flush = fl;
  assign if_r.i_wire_write = wr;
  assign if_r.i_wire_data_in = din;
  assign if_r.i_wire_read = rd;
  assign if_r.i_wire_almost_full_threshold = af_thr;
  assign if_r.i_wire_almost_empty_threshold = ae_thr;

  painterengine_gpu_sync_fifo #(
    .PARAM_DATA_WIDTH(DW), .PARAM_FIFO_DEPTH(DEPTH), .PARAM_FWFT(1'b1)
  ) u_fwft (
    .i_wire_write_clock(clk), .i_wire_resetn(rstn), .fifo_if(if_f)
  );

  painterengine_gpu_sync_fifo #(
    .PARAM_DATA_WIDTH(DW), .PARAM_FIFO_DEPTH(DEPTH), .PARAM_FWFT(1'b0)
  ) u_reg (
    .i_wire_write_clock(clk), .i_wire_resetn(rstn), .fifo_if(if_r)
  );

  // Behavioural model: a word queue, sticky error bits and the registered-read output.
  logic [DW-1:0] mq[$];
  bit            m_ov = 1'b0, m_un = 1'b0, m_rv = 1'b0;
  logic [DW-1:0] m_rd = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_ov = 1'b0; m_un = 1'b0; m_rv = 1'b0; m_rd = '0;
    end else if (fl) begin
      mq.delete();
      m_ov = 1'b0; m_un = 1'b0; m_rv = 1'b0;
    end else begin
      bit ra, wa;
      ra   = rd && (mq.size() != 0);
      wa   = wr && ((mq.size() < DEPTH) || ra);
      m_rv = ra;
      if (ra) m_rd = mq.pop_front();
      if (wa) mq.push_back(din);
      if (wr && !wa) m_ov = 1'b1;
      if (rd && !ra) m_un = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = mq.size();
      chk("f.data_out",  if_f.o_wire_data_out, (n != 0) ? mq[0] : '0);
      chk("f.valid",     DW'(if_f.o_wire_data_valid), DW'(n != 0));
      chk("r.data_out",  if_r.o_wire_data_out, m_rd);
      chk("r.valid",     DW'(if_r.o_wire_data_valid), DW'(m_rv));
      chk("f.full",      DW'(if_f.o_wire_full), DW'(n == DEPTH));
      chk("f.empty",     DW'(if_f.o_wire_empty), DW'(n == 0));
      chk("f.afull",     DW'(if_f.o_wire_almost_full), DW'(n >= int'(af_thr)));
      chk("f.aempty",    DW'(if_f.o_wire_almost_empty), DW'(n <= int'(ae_thr)));
      chk("f.count",     DW'(if_f.o_wire_data_count), DW'(n));
      chk("f.ecount",    DW'(if_f.o_wire_empty_count), DW'(DEPTH - n));
      chk("f.overflow",  DW'(if_f.o_wire_overflow), DW'(m_ov));
      chk("f.underflow", DW'(if_f.o_wire_underflow), DW'(m_un));
      chk("r.count",     DW'(if_r.o_wire_data_count), DW'(n));
      chk("r.overflow",  DW'(if_r.o_wire_overflow), DW'(m_ov));
      chk("r.underflow", DW'(if_r.o_wire_underflow), DW'(m_un));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fl = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_w [16];
    rstn = 1'b0; fl = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    af_thr = 5'd12; ae_thr = 5'd2;
    tick(); tick();
    rstn = 1'b1;
    chk_en = 1'b1;

    // Reset state
    chk("rst.empty",  DW'(if_f.o_wire_empty), 32'd1);
    chk("rst.full",   DW'(if_f.o_wire_full), 32'd0);
    chk("rst.count",  DW'(if_f.o_wire_data_count), 32'd0);
    chk("rst.ecount", DW'(if_f.o_wire_empty_count), 32'd16);
    chk("rst.r.data", if_r.o_wire_data_out, 32'd0);
    chk("rst.aempty", DW'(if_f.o_wire_almost_empty), 32'd1);

    // Fill with 0x100..0x10F; almost-full must rise exactly at count 12
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; din = 32'h100 + i;
      tick();
      chk("fill.afull", DW'(if_f.o_wire_almost_full), DW'((i + 1) >= 12));
      chk("fill.aempty", DW'(if_f.o_wire_almost_empty), DW'((i + 1) <= 2));
    end
    idle();
    chk("fill.full",   DW'(if_f.o_wire_full), 32'd1);
    chk("fill.count",  DW'(if_f.o_wire_data_count), 32'd16);
    chk("fill.ecount", DW'(if_f.o_wire_empty_count), 32'd0);
    chk("fill.head",   if_f.o_wire_data_out, 32'h100);

    // Read and write together while full
    rd = 1'b1; wr = 1'b1; din = 32'hBEEF;
    tick(); idle();
    chk("rw.count", DW'(if_f.o_wire_data_count), 32'd16);
    chk("rw.head",  if_f.o_wire_data_out, 32'h101);
    chk("rw.ovf",   DW'(if_f.o_wire_overflow), 32'd0);
    chk("rw.r.data", if_r.o_wire_data_out, 32'h100);

    // Rejected write while full
    wr = 1'b1; din = 32'hDEAD;
    tick(); idle();
    chk("ovf.flag",  DW'(if_f.o_wire_overflow), 32'd1);
    chk("ovf.count", DW'(if_f.o_wire_data_count), 32'd16);

    // Drain: 0x101..0x10F then 0xBEEF, never 0xDEAD
    for (int i = 0; i < 15; i++) exp_w[i] = 32'h101 + i;
    exp_w[15] = 32'hBEEF;
    for (int i = 0; i < 16; i++) begin
      chk("drain.f.data", if_f.o_wire_data_out, exp_w[i]);
      rd = 1'b1;
      tick();
      chk("drain.r.data", if_r.o_wire_data_out, exp_w[i]);
    end
    idle();
    chk("drain.empty", DW'(if_f.o_wire_empty), 32'd1);
    chk("drain.ovf",   DW'(if_f.o_wire_overflow), 32'd1);
    chk("drain.unf",   DW'(if_f.o_wire_underflow), 32'd0);

    // Rejected read while empty; both flags stay sticky
    rd = 1'b1;
    tick(); idle();
    tick(); tick();
    chk("unf.flag",   DW'(if_f.o_wire_underflow), 32'd1);
    chk("unf.ovf",    DW'(if_f.o_wire_overflow), 32'd1);
    chk("unf.r.vld",  DW'(if_r.o_wire_data_valid), 32'd0);

    // Flush together with a write drops the write and clears flags
    wr = 1'b1; din = 32'h3;
    tick(); idle();
    wr = 1'b1; din = 32'h55; fl = 1'b1;
    tick(); idle();
    chk("flush.count", DW'(if_f.o_wire_data_count), 32'd0);
    chk("flush.ovf",   DW'(if_f.o_wire_overflow), 32'd0);
    chk("flush.unf",   DW'(if_f.o_wire_underflow), 32'd0);
    chk("flush.vld",   DW'(if_f.o_wire_data_valid), 32'd0);

    // Pointer wrap with occupancy held at 3
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; din = 32'h200 + i;
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      chk("wrap.f.data", if_f.o_wire_data_out, 32'h200 + i);
      wr = 1'b1; rd = 1'b1; din = 32'h203 + i;
      tick();
      chk("wrap.count", DW'(if_f.o_wire_data_count), 32'd3);
      chk("wrap.r.data", if_r.o_wire_data_out, 32'h200 + i);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1;
      tick();
      chk("wrap.tail", if_r.o_wire_data_out, 32'h228 + i);
    end
    idle();

    // Registered read: 0xA then 0xB, valid one cycle after each read
    wr = 1'b1; din = 32'hA; tick();
    din = 32'hB; tick();
    idle(); tick();
    chk("reg.idle.vld", DW'(if_r.o_wire_data_valid), 32'd0);
    rd = 1'b1; tick();
    chk("reg.vld0", DW'(if_r.o_wire_data_valid), 32'd1);
    chk("reg.dat0", if_r.o_wire_data_out, 32'hA);
    tick(); idle();
    chk("reg.vld1", DW'(if_r.o_wire_data_valid), 32'd1);
    chk("reg.dat1", if_r.o_wire_data_out, 32'hB);
    tick();
    chk("reg.vld2", DW'(if_r.o_wire_data_valid), 32'd0);
    chk("reg.hold", if_r.o_wire_data_out, 32'hB);

    // Threshold extremes on an empty FIFO
    af_thr = 5'd0; #1;
    chk("thr.af0", DW'(if_f.o_wire_almost_full), 32'd1);
    af_thr = 5'd17; #1;
    chk("thr.af17", DW'(if_f.o_wire_almost_full), 32'd0);
    ae_thr = 5'd0; #1;
    chk("thr.ae0", DW'(if_f.o_wire_almost_empty), 32'd1);
    wr = 1'b1; din = 32'h77; tick(); idle();
    chk("thr.ae0.one", DW'(if_f.o_wire_almost_empty), 32'd0);
    af_thr = 5'd1; #1;
    chk("thr.af1", DW'(if_f.o_wire_almost_full), 32'd1);
    af_thr = 5'd12; ae_thr = 5'd2;
    tick();

    // Asynchronous reset in the middle of traffic
    wr = 1'b1; din = 32'h300; tick();
    din = 32'h301; #2;
    rstn = 1'b0; #2;
    chk("arst.empty", DW'(if_f.o_wire_empty), 32'd1);
    chk("arst.r.data", if_r.o_wire_data_out, 32'd0);
    #2;
    rstn = 1'b1; din = 32'h302;
    tick(); idle();
    chk("arst.count", DW'(if_f.o_wire_data_count), 32'd1);
    chk("arst.head",  if_f.o_wire_data_out, 32'h302);
    tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/painterengine_gpu_sync_fifo.md
# painterengine_gpu_sync_fifo

Parametrised single-clock FIFO for the GPU IP. It replaces the fixed 9-bit-count FIFO on command and pixel paths that run in one clock domain. Compared with that FIFO, it adds selectable first-word-fall-through (FWFT) or registered-read mode, programmable almost-full and almost-empty thresholds, simultaneous read/write when full, synchronous flush, and sticky overflow/underflow flags. Counter widths are derived from depth.

## Interface
Parameters:
- PARAM_DATA_WIDTH, 32, data word width in bits (1..1024).
- PARAM_FIFO_DEPTH, 64, number of entries; power of two, 4..4096.
- PARAM_FWFT, 1, output mode: 1 = first-word-fall-through, 0 = registered read.
- CW (localparam), clog2(PARAM_FIFO_DEPTH)+1, width of all count and threshold signals.

Ports:
- i_wire_write_clock  in  1  sole clock; the read side also runs on it.
- i_wire_resetn  in  1  reset; asynchronous, active-low.
- i_wire_flush  in  1  synchronous clear of pointers and sticky flags.
- i_wire_write  in  1  write request.
- i_wire_data_in  in  PARAM_DATA_WIDTH  write data.
- i_wire_read  in  1  read request (in FWFT mode, acknowledge of the head word).
- i_wire_almost_full_threshold  in  CW  almost-full level.
- i_wire_almost_empty_threshold  in  CW  almost-empty level.
- o_wire_data_out  out  PARAM_DATA_WIDTH  read data.
- o_wire_data_valid  out  1  o_wire_data_out holds a valid word.
- o_wire_full  out  1  count == DEPTH.
- o_wire_almost_full  out  1  count >= almost-full threshold.
- o_wire_empty  out  1  count == 0.
- o_wire_almost_empty  out  1  count <= almost-empty threshold.
- o_wire_data_count  out  CW  stored words.
- o_wire_empty_count  out  CW  DEPTH − count.
- o_wire_overflow  out  1  sticky: a write was rejected.
- o_wire_underflow  out  1  sticky: a read was rejected.

## Operation
- Storage is a PARAM_FIFO_DEPTH × PARAM_DATA_WIDTH array. The array is not reset.
- Pointers:
  - wr_ptr and rd_ptr are CW bits wide.
  - The array index is the low CW−1 bits; the MSB is the wrap bit.
  - count = wr_ptr − rd_ptr (mod 2^CW), which spans the full range 0..DEPTH.
- Read acceptance: rd_acc = i_wire_read && count != 0.
- Write acceptance: wr_acc = i_wire_write && (count < DEPTH || rd_acc). A write is therefore accepted when full if a read is accepted in the same cycle.
- Rejected requests:
  - A write with wr_acc = 0 sets o_wire_overflow.
  - A read with rd_acc = 0 sets o_wire_underflow.
  - The FIFO state is otherwise unchanged.
- Counting: an accepted write increments wr_ptr; an accepted read increments rd_ptr. When both are accepted, count is unchanged.
- Flush:
  - i_wire_flush has priority over read and write in the same cycle; those requests are dropped without raising error flags.
  - Flush sets wr_ptr = rd_ptr = 0 and clears both sticky flags and o_wire_data_valid.
  - Sticky flags are cleared only by reset or flush.
- FWFT mode (PARAM_FWFT=1):
  - o_wire_data_out = mem[rd_ptr] when count != 0, else 0.
  - o_wire_data_valid = (count != 0).
  - Asserting i_wire_read pops the displayed word.
- Registered mode (PARAM_FWFT=0):
  - On rd_acc, o_wire_data_out <= mem[rd_ptr] and o_wire_data_valid <= 1 for exactly one cycle.
  - Otherwise o_wire_data_valid <= 0 and o_wire_data_out holds its value.
- Thresholds:
  - Compared live against count as unsigned values.
  - A threshold of 0 makes almost-full always 1; a threshold above DEPTH makes almost-full always 0.

## Timing
- Reset (asynchronous) clears pointers, sticky flags and o_wire_data_valid, and sets o_wire_data_out = 0.
- After reset: o_wire_empty=1, o_wire_full=0, o_wire_data_count=0, o_wire_empty_count=DEPTH. Almost-full and almost-empty follow their thresholds.
- Status flags and counts are combinational from the registered pointers, so they update in the cycle after the accepting clock edge.
- FWFT latency: a write accepted at edge N into an empty FIFO gives o_wire_data_valid=1 with that word from edge N (visible in cycle N+1).
- Registered latency: a read accepted at edge N gives its data valid in the cycle following edge N. Sustained throughput is one word per cycle.
- Wrap-around: pointers wrap modulo 2^CW, and count stays correct across the wrap.
- Reset deasserted mid-traffic: the first edge after deassertion behaves as a normal cycle from the empty state.

## Test plan
- Fill/drain, DEPTH=16, WIDTH=32, FWFT=1:
  - Write 0x100..0x10F on 16 consecutive cycles → full=1, data_count=16, empty_count=0.
  - Then read 16 times → words come out in order 0x100..0x10F, empty=1, no error flags.
- Overflow and underflow:
  - Full FIFO plus write 0xDEAD → overflow=1, count stays 16, 0xDEAD is never read out.
  - Empty FIFO plus read → underflow=1.
  - Both flags stay set until flush.
- Simultaneous read and write at full: full FIFO, read and write 0xBEEF in the same cycle → count stays 16, head advances, 0xBEEF is the 16th word read, no overflow.
- Pointer wrap: 40 cycles of interleaved write/read with occupancy held at 3 → all words come out in order, data_count reads 3 throughout steady state.
- Registered mode (FWFT=0): write 0xA, 0xB, then read on two consecutive cycles → valid pulses 2 cycles, data 0xA then 0xB one cycle after each read.
- Thresholds and flush:
  - almost_full_threshold=12, almost_empty_threshold=2 → almost_full asserts at count 12; almost_empty asserts at counts 0..2.
  - Flush asserted together with write → count=0, the write is dropped, flags are cleared.
